ising_field_accum: RTL
======================

// Module: ising_field_accum
// PURPOSE
//  Downstream consumer of the matrix_512 AXI4-Lite coupling/spin registers. For each of the N rows of the
//  coupling matrix J, streams signed weights LANES per beat and accumulates the local field h_i = sum_j J_ij*s_j.
//  The spin s_j is +1 when bit j is 1 and -1 when it is 0.
//  Emits one signed field per row on a valid/ready stream, toward the spin-update/sampler stage.
// PARAMETERS
//  N      512  spins per vector = weights per row (multiple of LANES)
//  LANES  8    weights per input beat
//  W_W    8    signed weight width
//  ACC_W  18   accumulator/output width; must be >= W_W+clog2(N)+1
// PORTS
//  ACLK        in   1              clock
//  ARESETN     in   1              async active-low reset
//  spin_load   in   1              pulse: capture spin_data into spin register (ignored while busy)
//  spin_data   in   N              spin vector, bit j = s_j
//  start       in   1              pulse: begin N-row pass (ignored while busy)
//  s_w_valid   in   1              weight beat valid
//  s_w_ready   out  1              weight beat accepted when valid&ready
//  s_w_data    in   LANES*W_W      lane k = bits[k*W_W +: W_W] = J[row][beat*LANES+k]
//  s_w_last    in   1              producer marks last beat of row
//  m_f_valid   out  1              field valid
//  m_f_ready   in   1              downstream accepts field
//  m_f_data    out  ACC_W          signed field h_row
//  m_f_row     out  clog2(N)       row index of m_f_data
//  busy        out  1              pass in progress
//  err_len     out  1              sticky: s_w_last disagreed with beat count
// BEHAVIOUR
//  Reset: all outputs 0. Spin register, accumulator, beat counter and row counter are 0. FSM is in IDLE.
//  FSM states:
//   IDLE  -> ACCUM on start. On that transition: clear acc, beat=0, row=0, err_len=0, busy=1.
//   ACCUM -> OUT when the beat numbered N/LANES-1 is accepted.
//   OUT   -> ACCUM on m_f_valid&m_f_ready if row<N-1: row++, acc=0, beat=0.
//   OUT   -> IDLE on m_f_valid&m_f_ready if row==N-1: busy=0.
//  s_w_ready = 1 only in ACCUM. There is no combinational path from m_f_ready to s_w_ready.
//  Accumulate on an accepted beat: acc += sum_k(spin[beat*LANES+k] ? +J_k : -J_k). Single cycle.
//   Weights are sign-extended to ACC_W. The sum cannot overflow at the defaults.
//  Latency: m_f_valid is registered and rises the cycle after the final beat is accepted.
//   m_f_data and m_f_row are held stable while valid&!ready.
//  Row length is fixed by the beat counter, not by s_w_last.
//   err_len is set if s_w_last=1 on a beat other than the last, or s_w_last=0 on the last beat.
//   The row still completes at beat N/LANES-1. err_len is cleared only by start or reset.
//  spin_load during a pass is ignored. start during a pass is ignored.
//   start and spin_load in the same IDLE cycle: the pass uses the newly loaded spins.
//  Reset mid-pass: returns to IDLE immediately. Any partial field is discarded and never emitted.
// CONFIGURATION
//  ISING_FIELD_SIGN_EN defined:
//   Adds output port m_f_sign (1 bit) = (m_f_data >= 0). This is the proposed next spin.
//   It is registered with m_f_data, shares m_f_valid, and resets to 0.
//  ISING_FIELD_SIGN_EN undefined: port and logic are absent. All other behaviour is identical.
// TESTING (N=512, LANES=8, W_W=8)
//  All J=+1, spins all 1 -> 512 fields, each m_f_data=512, m_f_row 0..511, then busy=0.
//  All J=+1, spins all 0 -> every m_f_data=-512 (0x3FE00). With SIGN_EN, m_f_sign=0.
//  All J=-128, spins all 1 -> m_f_data=-65536 (no wrap). J=127 with spins alternating 1/0 -> m_f_data=0.
//  Hold m_f_ready=0 for 5 cycles after row 0 -> data and row stay stable, s_w_ready=0.
//   Release -> handshake completes and row 1 starts.
//  s_w_last=1 on beat 10 of row 3 -> err_len=1. Row 3 still consumes 64 beats.
//   Field is correct. err_len clears on next start.
//  ARESETN low at beat 30 of row 7 -> all outputs 0 and busy=0. A new start gives row 0 with correct fields.

Source files
------------

// File: rtl/ising_field_accum.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | ising_field_accum: streams LANES signed couplings per beat per row of J |
// | and emits h_i = sum_j J_ij*s_j per row on a valid/ready stream.         |
// | Optional: ISING_FIELD_SIGN_EN adds m_f_sign = (m_f_data >= 0).          |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module ising_field_accum #(
  parameter int N     = 512,
  parameter int LANES = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 18
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   spin_load,
  input  logic [N-1:0]           spin_data,
  input  logic                   start,
  input  logic                   s_w_valid,
  output logic                   s_w_ready,
  input  logic [LANES*W_W-1:0]   s_w_data,
  input  logic                   s_w_last,
  output logic                   m_f_valid,
  input  logic                   m_f_ready,
  output logic [ACC_W-1:0]       m_f_data,
  output logic [$clog2(N)-1:0]   m_f_row,
  output logic                   busy,
`ifdef ISING_FIELD_SIGN_EN
  output logic                   m_f_sign,
`endif
  output logic                   err_len
);

  localparam int c_nbeats = N / LANES;
  localparam int c_beat_w = (c_nbeats > 1) ? $clog2(c_nbeats) : 1;
  localparam int c_row_w  = $clog2(N);
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_nbeats - 1);
  localparam logic [c_row_w-1:0]  c_last_row  = c_row_w'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t               state_q;
  logic [N-1:0]         spin_q;
  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     acc_d;
  logic [c_beat_w-1:0]  beat_q;
  logic [c_row_w-1:0]   row_q;
  logic                 s_w_ready_q;
  logic                 m_f_valid_q;
  logic [ACC_W-1:0]     m_f_data_q;
  logic [c_row_w-1:0]   m_f_row_q;
  logic                 busy_q;
  logic                 err_len_q;
  logic                 m_f_sign_q;

  logic [LANES-1:0]     w_spin_slice;
  logic signed [W_W-1:0] w_lane;
  logic [ACC_W-1:0]     w_ext;
  logic [ACC_W-1:0]     w_beat_sum;
  logic                 w_accept;
  logic                 w_last_beat;

  assign w_spin_slice = spin_q[int'(beat_q)*LANES +: LANES];
  assign w_accept     = s_w_valid && s_w_ready_q;
  assign w_last_beat  = (beat_q == c_last_beat);

  // Spin bit selects +J or -J; each lane is sign-extended before the add.
  always_comb begin
    w_beat_sum = '0;
    w_lane     = '0;
    w_ext      = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane = s_w_data[k*W_W +: W_W];
      w_ext  = {{(ACC_W-W_W){w_lane[W_W-1]}}, w_lane};
      if (w_spin_slice[k]) w_beat_sum = w_beat_sum + w_ext;
      else                 w_beat_sum = w_beat_sum - w_ext;
    end
    acc_d = acc_q + w_beat_sum;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      spin_q      <= '0;
      acc_q       <= '0;
      beat_q      <= '0;
      row_q       <= '0;
      s_w_ready_q <= 1'b0;
      m_f_valid_q <= 1'b0;
      m_f_data_q  <= '0;
      m_f_row_q   <= '0;
      busy_q      <= 1'b0;
      err_len_q   <= 1'b0;
      m_f_sign_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (spin_load) spin_q <= spin_data;
          if (start) begin
            state_q     <= S_ACCUM;
            acc_q       <= '0;
            beat_q      <= '0;
            row_q       <= '0;
            err_len_q   <= 1'b0;
            busy_q      <= 1'b1;
            s_w_ready_q <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            acc_q <= acc_d;
            // Row length comes from the beat counter; s_w_last is only audited.
            if (s_w_last != w_last_beat) err_len_q <= 1'b1;
            if (w_last_beat) begin
              state_q     <= S_OUT;
              s_w_ready_q <= 1'b0;
              m_f_valid_q <= 1'b1;
              m_f_data_q  <= acc_d;
              m_f_row_q   <= row_q;
              m_f_sign_q  <= ~acc_d[ACC_W-1];
            end else begin
              beat_q <= beat_q + c_beat_w'(1);
            end
          end
        end
        S_OUT: begin
          if (m_f_ready) begin
            m_f_valid_q <= 1'b0;
            if (row_q == c_last_row) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q     <= S_ACCUM;
              row_q       <= row_q + c_row_w'(1);
              acc_q       <= '0;
              beat_q      <= '0;
              s_w_ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_w_ready = s_w_ready_q;
  assign m_f_valid = m_f_valid_q;
  assign m_f_data  = m_f_data_q;
  assign m_f_row   = m_f_row_q;
  assign busy      = busy_q;
  assign err_len   = err_len_q;

`ifdef ISING_FIELD_SIGN_EN
  assign m_f_sign = m_f_sign_q;
`else
  logic w_sign_unused;
  assign w_sign_unused = m_f_sign_q;
`endif

endmodule
`default_nettype wire
